cache_dm: RTL
=============

# cache_dm

Direct-mapped, write-through, no-write-allocate cache that sits between the CPU load/store port and the word-addressed `ram` block. It is the initiator on the RAM's chip-enable/output-enable/write-enable bus. It serves read hits from its line array and forwards misses and all writes to RAM. It owns the bidirectional `mem_data` bus and the read-to-write turnaround on it.

## Interface
- `LINES`, 8: number of one-word lines; power of 2, ≥2.
- `MEM_LAT`, 1: RAM read latency in cycles from the `ce_n`/`oe_n` sample edge to data capture; ≥1.
- `BASE_ADDR`, 32'h10010000: byte address mapped to RAM word 0.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  one-cycle request strobe; only accepted in IDLE.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_byte`  in  1  on write: 1 = byte write (low byte only).
- `cpu_addr`  in  32  byte address, word aligned.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data; valid while `cpu_ack`=1 for a read.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_busy`  out  1  1 whenever state ≠ IDLE.
- `mem_addr`  out  32  RAM word index.
- `mem_data`  inout  32  driven only in WR; otherwise 'z.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1  active-low RAM controls.
- `mem_bw`  out  1  0 = byte write; 1 = full word.

## Operation
- Address mapping:
  - word = (cpu_addr − BASE_ADDR) >> 2, 30 bits, zero-extended onto `mem_addr`.
  - index = word[log2(LINES)−1:0]; tag = remaining upper bits of word.
- Line state: valid bit, tag and 32-bit data per line. Reset clears all valid bits; tags and data are not reset.
- FSM states: IDLE, CHECK, WR, RD_ISSUE, RD_WAIT, TURN.
- IDLE: on `cpu_req`=1, latch we/byte/addr/wdata and go to CHECK. A `cpu_req` in any other state is ignored and has no later effect.
- CHECK, read hit: `cpu_ack`=1 and `cpu_rdata`=line data on the next cycle; go to IDLE.
- CHECK, read miss: go to RD_ISSUE.
- CHECK, write: go to WR.
  - Word write hit: update line data.
  - Byte write hit: clear the line's valid bit. RAM stores wdata & 0xFF, zeroing the upper bytes, so the line would no longer match RAM.
  - Write miss: no allocation.
- WR, one cycle:
  - `mem_ce_n`=0, `mem_we_n`=0, `mem_oe_n`=1.
  - `mem_bw`=~byte; `mem_data`=wdata; `mem_addr`=word.
  - Then `cpu_ack` pulses and the FSM returns to IDLE.
- RD_ISSUE, one cycle: `mem_ce_n`=0, `mem_oe_n`=0, `mem_we_n`=1, `mem_addr`=word; go to RD_WAIT.
- RD_WAIT: stay MEM_LAT cycles, then sample `mem_data`.
  - Fill the line: valid=1, tag, data.
  - Drive `cpu_rdata`=sampled data with a `cpu_ack` pulse.
  - Go to TURN.
- TURN: one idle cycle so the RAM releases `mem_data` before any WR drive; then IDLE.
- Outside WR and RD_ISSUE: all `mem_*_n`=1, `mem_bw`=1.

## Timing
- Reset values: `cpu_ack`=0, `cpu_rdata`=0, `cpu_busy`=0, `mem_ce_n`/`mem_oe_n`/`mem_we_n`=1, `mem_bw`=1, `mem_addr`=0, `mem_data`='z. State = IDLE.
- Reset mid-operation aborts the access immediately. The bus returns to reset values on the next cycle and no `cpu_ack` is issued.
- Latency, in cycles from the edge sampling `cpu_req` (E0) to the edge starting the `cpu_ack` cycle:
  - Read hit: 2.
  - Write (hit or miss): 3.
  - Read miss: 3 + MEM_LAT.
- Read miss: `cpu_ack` is high during the TURN cycle; the next request is accepted one cycle after `cpu_ack` falls.
- `mem_*` outputs are registered, with no combinational path from `cpu_*`.
- A read of a line written in the immediately preceding request sees the new data on a word-write hit, and misses after a byte write.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` (32) and `miss_cnt` (32), reset to 0.
  - A CHECK read hit increments `hit_cnt`; a CHECK read miss increments `miss_cnt`. Writes count in neither.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold read of 0x10010010 with RAM word 4 = 0xDEADBEEF (MEM_LAT=1):
  - `mem_ce_n`/`mem_oe_n` low for exactly 1 cycle with `mem_addr`=4.
  - `cpu_ack` 4 cycles after E0 with `cpu_rdata`=0xDEADBEEF.
  - Repeat read: ack after 2 cycles, no `mem_ce_n` activity.
- Word write 0x12345678 to 0x10010010 after it is cached:
  - WR cycle with `mem_bw`=1 and `mem_data`=0x12345678.
  - Following read hits and returns 0x12345678.
- Byte write 0xAABBCCDD to the same cached address:
  - `mem_bw`=0.
  - Next read misses and returns the RAM value 0x000000DD.
- Conflict: read 0x10010000, then 0x10010020 (LINES=8, same index):
  - Both miss.
  - Re-read of 0x10010000 misses again.
- `cpu_req` pulsed during RD_WAIT, and `rst_n`=0 asserted in RD_WAIT:
  - The stray request produces no extra access.
  - Reset gives no ack, controls return to 1, and all lines are invalid afterwards.
- With `CACHE_STATS_EN`, sequence miss, hit, hit, write: `hit_cnt`=2, `miss_cnt`=1.

Source files
------------

// File: rtl/cache_dm.sv
// cache_dm: direct-mapped, write-through, no-write-allocate cache between the
// CPU load/store port and a word-addressed RAM with active-low CE/OE/WE.
// The cache owns the bidirectional mem_data bus. It drives the bus only in WR.
// After each read it inserts a TURN cycle so the RAM can release the bus.
// Optional feature: define CACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
module cache_dm #(
    parameter int unsigned LINES     = 8,
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic [31:0] mem_addr,
    inout  logic [31:0] mem_data,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_bw
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] WR       = 3'd2;
    localparam logic [2:0] RD_ISSUE = 3'd3;
    localparam logic [2:0] RD_WAIT  = 3'd4;
    localparam logic [2:0] TURN     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             we_q, we_d;
    logic             byte_q, byte_d;
    logic [29:0]      word_q, word_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ce_n_q, ce_n_d;
    logic             oe_n_q, oe_n_d;
    logic             we_n_q, we_n_d;
    logic             bw_q, bw_d;
    logic [31:0]      maddr_q, maddr_d;
    logic             drv_q, drv_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

`ifdef CACHE_STATS_EN
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
`endif

    logic [31:0]      cpu_off;
    logic             unused_off_bits;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;

    // Word index relative to the RAM base; the byte-offset bits are dropped.
    assign cpu_off         = cpu_addr - BASE_ADDR;
    assign unused_off_bits = ^cpu_off[1:0];

    assign idx = word_q[IDX_W-1:0];
    assign tag = word_q[29:IDX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    // Next-state, line-update and registered-output logic for the access FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        bw_d    = 1'b1;
        maddr_d = maddr_q;
        drv_d   = 1'b0;
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
`ifdef CACHE_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    byte_d  = cpu_byte;
                    word_d  = cpu_off[31:2];
                    wdata_d = cpu_wdata;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (we_q) begin
                    // A byte write leaves RAM holding wdata & 0xFF, so a hit
                    // line would go stale.  Drop the line instead of patching it.
                    if (hit) begin
                        if (byte_q) begin
                            valid_d[idx] = 1'b0;
                        end else begin
                            data_d[idx] = wdata_q;
                        end
                    end
                    ce_n_d  = 1'b0;
                    we_n_d  = 1'b0;
                    bw_d    = ~byte_q;
                    drv_d   = 1'b1;
                    maddr_d = {2'b00, word_q};
                    state_d = WR;
                end else if (hit) begin
                    ack_d   = 1'b1;
                    rdata_d = data_q[idx];
                    state_d = IDLE;
`ifdef CACHE_STATS_EN
                    hit_cnt_d = hit_cnt_q + 32'd1;
`endif
                end else begin
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    maddr_d = {2'b00, word_q};
                    state_d = RD_ISSUE;
`ifdef CACHE_STATS_EN
                    miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                end
            end
            WR: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    valid_d[idx] = 1'b1;
                    tag_d[idx]   = tag;
                    data_d[idx]  = mem_data;
                    rdata_d      = mem_data;
                    ack_d        = 1'b1;
                    state_d      = TURN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, bus and valid-bit flops; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            bw_q    <= 1'b1;
            maddr_q <= '0;
            drv_q   <= 1'b0;
            valid_q <= '0;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            bw_q    <= bw_d;
            maddr_q <= maddr_d;
            drv_q   <= drv_d;
            valid_q <= valid_d;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    // Line tags and data are left unreset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign cpu_ack   = ack_q;
    assign cpu_rdata = rdata_q;
    assign cpu_busy  = (state_q != IDLE);
    assign mem_addr  = maddr_q;
    assign mem_ce_n  = ce_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;
    assign mem_bw    = bw_q;
    assign mem_data  = drv_q ? wdata_q : 'z;

`ifdef CACHE_STATS_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
